// File: rtl/writeback_unit_if.sv
// ============================================================================
// Interface : writeback_unit_if
// Brief     : Result inputs, load handshake, register-file write and hazard query.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface writeback_unit_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              CNTRL_RS;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] ALU_WB;
    logic [c_CNT_W-1:0] pending;
    logic [ADDR_W-1:0] q_rs;
    logic              q_hit;

    // Pipeline side: offers results, consumes the register-file write.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data, q_rs,
        input  mem_ready, CNTRL_RS, rd, ALU_WB, pending, q_hit
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data, q_rs,
        output mem_ready, CNTRL_RS, rd, ALU_WB, pending, q_hit
    );
endinterface

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// Module   : writeback_unit
// Brief    : Merges ALU and load results into one register-file write per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_unit #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  wire logic       clk,
    input  wire logic       reset,
    writeback_unit_if.slave bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  r_fifo_rd   [DEPTH];
    logic [DATA_W-1:0]  r_fifo_data [DEPTH];
    logic [DEPTH-1:0]   r_kill;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_we;
    logic [ADDR_W-1:0]  r_rd;
    logic [DATA_W-1:0]  r_data;

    logic               w_full;
    logic               w_mem_ready;
    logic               w_push;
    logic               w_alu_take;
    logic               w_pop;
    logic               w_head_live;
    logic [DEPTH-1:0]   w_occ;
    logic [DEPTH-1:0]   w_live;
    logic [DEPTH-1:0]   w_kill_set;
    logic [DEPTH-1:0]   w_qhit_vec;

    assign w_full      = (r_count == c_FULL);
    assign w_mem_ready = !w_full && !reset;
    // A load to x0 completes its handshake but never occupies a slot.
    assign w_push      = bus.mem_valid && w_mem_ready && (bus.mem_rd != '0);
    assign w_alu_take  = bus.alu_valid && (bus.alu_rd != '0);
    assign w_pop       = !w_alu_take && (r_count != '0);
    assign w_head_live = !r_kill[r_rptr];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [c_PTR_W-1:0] w_rel;
        assign w_rel          = c_PTR_W'(gi) - r_rptr;
        assign w_occ[gi]      = ({1'b0, w_rel} < r_count);
        assign w_live[gi]     = w_occ[gi] && !r_kill[gi];
        assign w_kill_set[gi] = w_alu_take && w_live[gi] && (r_fifo_rd[gi] == bus.alu_rd);
        assign w_qhit_vec[gi] = w_live[gi] && (r_fifo_rd[gi] == bus.q_rs);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_kill  <= '0;
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
        end else begin
            // The slot being pushed is never occupied, so its fresh clear wins.
            r_kill <= r_kill | w_kill_set;
            if (w_push) begin
                r_fifo_rd[r_wptr]   <= bus.mem_rd;
                r_fifo_data[r_wptr] <= bus.mem_data;
                r_kill[r_wptr]      <= 1'b0;
                r_wptr              <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_alu_take) begin
                r_we   <= 1'b1;
                r_rd   <= bus.alu_rd;
                r_data <= bus.alu_data;
            end else if (w_pop) begin
                r_we <= w_head_live;
                if (w_head_live) begin
                    r_rd   <= r_fifo_rd[r_rptr];
                    r_data <= r_fifo_data[r_rptr];
                end
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign bus.mem_ready = w_mem_ready;
    assign bus.CNTRL_RS  = r_we;
    assign bus.rd        = r_rd;
    assign bus.ALU_WB    = r_data;
    assign bus.pending   = r_count;
    assign bus.q_hit     = (|w_qhit_vec) && (bus.q_rs != '0);

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// Module   : tb_writeback_unit
// Brief    : Scoreboard bench for writeback_unit register-file write ordering.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_unit;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    wr_t  sb[$];
    wr_t  mon_exp;

    writeback_unit_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    writeback_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.CNTRL_RS === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", bus.rd, bus.ALU_WB);
            end else begin
                mon_exp = sb.pop_front();
                if (bus.rd !== mon_exp.rd || bus.ALU_WB !== mon_exp.data) begin
                    errors++;
                    $display("FAIL write_order: got rd=%0d data=%h, expected rd=%0d data=%h",
                             bus.rd, bus.ALU_WB, mon_exp.rd, mon_exp.data);
                end
            end
        end
    end

    function automatic wr_t mk(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        wr_t w;
        w.rd   = r;
        w.data = d;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = '0;
        bus.mem_data  = '0;
    endtask

    task automatic test_reset();
        idle();
        bus.q_rs = '0;
        reset = 1'b1;
        tick();
        checks++; if (bus.CNTRL_RS !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.CNTRL_RS); end
        checks++; if (bus.rd !== '0 || bus.ALU_WB !== '0) begin errors++; $display("FAIL reset_rd_data: got rd=%0d data=%h expected 0/0", bus.rd, bus.ALU_WB); end
        checks++; if (bus.pending !== '0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", bus.pending); end
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", bus.mem_ready); end
        reset = 1'b0;
        tick();
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b expected 1", bus.mem_ready); end
    endtask

    task automatic test_alu_basic();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 32'h11;
        sb.push_back(mk(5'd3, 32'h11));
        tick();
        idle();
        checks++; if (bus.CNTRL_RS !== 1'b1 || bus.rd !== 5'd3 || bus.ALU_WB !== 32'h11) begin
            errors++; $display("FAIL alu_write: got we=%b rd=%0d data=%h expected 1/3/11", bus.CNTRL_RS, bus.rd, bus.ALU_WB); end
        tick();
        checks++; if (bus.CNTRL_RS !== 1'b0 || bus.rd !== 5'd3) begin
            errors++; $display("FAIL alu_idle_hold: got we=%b rd=%0d expected 0/3", bus.CNTRL_RS, bus.rd); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL alu_drain: got %0d outstanding expected 0", sb.size()); end
    endtask

    task automatic test_fifo_full();
        wr_t hold[$];
        int  ld = 10;
        for (int c = 0; c < 15; c++) begin
            if (c <= 6) begin
                checks++; if (bus.mem_ready !== (c < 4)) begin
                    errors++; $display("FAIL full_ready c=%0d: got %b expected %b", c, bus.mem_ready, (c < 4)); end
            end
            if (c == 6) begin
                checks++; if (bus.pending !== 3'd4) begin errors++; $display("FAIL full_pending: got %0d expected 4", bus.pending); end
                while (hold.size() > 0) sb.push_back(hold.pop_front());
            end
            checks++; if (bus.CNTRL_RS !== (c >= 1 && c <= 12)) begin
                errors++; $display("FAIL full_we c=%0d: got %b expected %b", c, bus.CNTRL_RS, (c >= 1 && c <= 12)); end
            if (c < 6) begin
                bus.alu_valid = 1'b1;
                bus.alu_rd    = ADDR_W'(c + 1);
                bus.alu_data  = DATA_W'(256 + c);
                sb.push_back(mk(ADDR_W'(c + 1), DATA_W'(256 + c)));
            end else begin
                bus.alu_valid = 1'b0;
            end
            if (ld <= 15) begin
                bus.mem_valid = 1'b1;
                bus.mem_rd    = ADDR_W'(ld);
                bus.mem_data  = DATA_W'(512 + ld);
                if (bus.mem_ready === 1'b1) begin
                    if (c < 6) hold.push_back(mk(ADDR_W'(ld), DATA_W'(512 + ld)));
                    else       sb.push_back(mk(ADDR_W'(ld), DATA_W'(512 + ld)));
                    ld++;
                end
            end else begin
                bus.mem_valid = 1'b0;
            end
            tick();
        end
        idle();
        checks++; if (ld != 16) begin errors++; $display("FAIL full_all_loads: got next=%0d expected 16", ld); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL full_drain: got %0d outstanding expected 0", sb.size()); end
    endtask

    task automatic test_waw_kill();
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h31;
        sb.push_back(mk(5'd1, 32'h31));
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'hAA;
        bus.q_rs = 5'd7;
        #1;
        checks++; if (bus.q_hit !== 1'b0) begin errors++; $display("FAIL kill_qhit_push: got %b expected 0", bus.q_hit); end
        tick();
        checks++; if (bus.q_hit !== 1'b1 || bus.pending !== 3'd1) begin
            errors++; $display("FAIL kill_queued: got qhit=%b pending=%0d expected 1/1", bus.q_hit, bus.pending); end
        bus.mem_valid = 1'b0;
        bus.alu_rd = 5'd7; bus.alu_data = 32'hBB;
        sb.push_back(mk(5'd7, 32'hBB));
        tick();
        idle();
        checks++; if (bus.q_hit !== 1'b0 || bus.pending !== 3'd1) begin
            errors++; $display("FAIL kill_qhit_after: got qhit=%b pending=%0d expected 0/1", bus.q_hit, bus.pending); end
        checks++; if (bus.CNTRL_RS !== 1'b1 || bus.ALU_WB !== 32'hBB) begin
            errors++; $display("FAIL kill_alu_write: got we=%b data=%h expected 1/bb", bus.CNTRL_RS, bus.ALU_WB); end
        tick();
        checks++; if (bus.CNTRL_RS !== 1'b0 || bus.pending !== 3'd0 || bus.rd !== 5'd7 || bus.ALU_WB !== 32'hBB) begin
            errors++; $display("FAIL kill_pop: got we=%b pending=%0d rd=%0d data=%h expected 0/0/7/bb",
                               bus.CNTRL_RS, bus.pending, bus.rd, bus.ALU_WB); end
        tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL kill_drain: got %0d outstanding expected 0", sb.size()); end
    endtask

    task automatic test_same_cycle();
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h1;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h2;
        sb.push_back(mk(5'd7, 32'h1));
        sb.push_back(mk(5'd7, 32'h2));
        bus.q_rs = 5'd7;
        tick();
        idle();
        checks++; if (bus.q_hit !== 1'b1 || bus.pending !== 3'd1) begin
            errors++; $display("FAIL same_not_killed: got qhit=%b pending=%0d expected 1/1", bus.q_hit, bus.pending); end
        tick();
        checks++; if (bus.CNTRL_RS !== 1'b1 || bus.ALU_WB !== 32'h2) begin
            errors++; $display("FAIL same_load_write: got we=%b data=%h expected 1/2", bus.CNTRL_RS, bus.ALU_WB); end
        tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL same_drain: got %0d outstanding expected 0", sb.size()); end
    endtask

    task automatic test_reg0();
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h55;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h99;
        sb.push_back(mk(5'd5, 32'h55));
        tick();
        checks++; if (bus.pending !== 3'd1) begin errors++; $display("FAIL reg0_queued: got %0d expected 1", bus.pending); end
        bus.alu_rd = 5'd0; bus.alu_data = 32'hDEAD;
        bus.mem_rd = 5'd0; bus.mem_data = 32'h77;
        sb.push_back(mk(5'd9, 32'h99));
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reg0_ready: got %b expected 1", bus.mem_ready); end
        tick();
        idle();
        checks++; if (bus.CNTRL_RS !== 1'b1 || bus.rd !== 5'd9) begin
            errors++; $display("FAIL reg0_pop: got we=%b rd=%0d expected 1/9", bus.CNTRL_RS, bus.rd); end
        checks++; if (bus.pending !== 3'd0) begin errors++; $display("FAIL reg0_pending: got %0d expected 0", bus.pending); end
        tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL reg0_drain: got %0d outstanding expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        idle();
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = ADDR_W'(20 + i); bus.alu_data = DATA_W'(768 + i);
            sb.push_back(mk(ADDR_W'(20 + i), DATA_W'(768 + i)));
            bus.mem_valid = 1'b1; bus.mem_rd = ADDR_W'(24 + i); bus.mem_data = DATA_W'(1024 + i);
            tick();
        end
        idle();
        bus.q_rs = 5'd24;
        #1;
        checks++; if (bus.pending !== 3'd3 || bus.q_hit !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: got pending=%0d qhit=%b expected 3/1", bus.pending, bus.q_hit); end
        reset = 1'b1;
        tick();
        checks++; if (bus.CNTRL_RS !== 1'b0 || bus.pending !== 3'd0 || bus.q_hit !== 1'b0) begin
            errors++; $display("FAIL rst_mid_clear: got we=%b pending=%0d qhit=%b expected 0/0/0",
                               bus.CNTRL_RS, bus.pending, bus.q_hit); end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (bus.pending !== 3'd0 || bus.mem_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_after: got pending=%0d ready=%b expected 0/1", bus.pending, bus.mem_ready); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rst_mid_drain: got %0d outstanding expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_fifo_full();
        test_waw_kill();
        test_same_cycle();
        test_reg0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
